eop_line_monitor: RTL and testbench
===================================

EOP_LINE_MONITOR -- requirements
Module: eop_line_monitor

Interface
REQ-001 Parameter EOP_BITS, default 2, minimum consecutive SE0 bit samples for a valid end-of-packet; legal range 1..RESET_BITS-1.
REQ-002 Parameter RESET_BITS, default 8, consecutive SE0 bit samples that declare bus reset; legal value >= 2.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port n_rst  input  1  asynchronous, active-low reset.
REQ-005 Port d_plus_sync  input  1  synchronised D+ line.
REQ-006 Port d_minus_sync  input  1  synchronised D- line.
REQ-007 Port shift_enable  input  1  one-clk bit-sample strobe; the line is sampled only when it is high.
REQ-008 Port eop  output  1  level; registered SE0 value of the most recent sample.
REQ-009 Port eop_done  output  1  one-clk pulse; valid EOP completed (SE0 run of at least EOP_BITS samples followed by a J sample).
REQ-010 Port eop_err  output  1  one-clk pulse; malformed SE0 run terminated.
REQ-011 Port se1_err  output  1  one-clk pulse; SE1 sampled.
REQ-012 Port bus_reset  output  1  level; asserted while a bus reset condition persists.

Function
REQ-013 Line states SHALL be decoded from (d_plus_sync, d_minus_sync): J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
REQ-014 All outputs SHALL be registered; each pulse output is high for exactly the clk cycle following the sampling edge and low otherwise.
REQ-015 On a sampling edge, eop SHALL load 1 if the sample is SE0, else 0; eop SHALL hold its value on edges where shift_enable is low.
REQ-016 The SE0 run counter SHALL be $clog2(RESET_BITS+1) bits wide, unsigned, and saturate at RESET_BITS (no wrap-around).
REQ-017 The FSM SHALL have states IDLE, IN_SE0 and RESET_HOLD; state and counter hold on edges where shift_enable is low.
REQ-018 IDLE, SE0 sample: go to IN_SE0 with counter = 1; if RESET_BITS equals 1 reached, treat as REQ-020.
REQ-019 IDLE, SE1 sample: pulse se1_err and stay in IDLE; J or K sample: stay in IDLE, no pulses.
REQ-020 IN_SE0, SE0 sample: increment counter; when the new value equals RESET_BITS, go to RESET_HOLD and set bus_reset on the same edge.
REQ-021 IN_SE0, J sample: pulse eop_done if counter >= EOP_BITS, else pulse eop_err; clear counter, go to IDLE.
REQ-022 IN_SE0, K sample: pulse eop_err; clear counter, go to IDLE.
REQ-023 IN_SE0, SE1 sample: pulse both se1_err and eop_err on the same cycle; clear counter, go to IDLE.
REQ-024 RESET_HOLD, SE0 sample: stay, bus_reset held at 1, counter saturated.
REQ-025 RESET_HOLD, any non-SE0 sample: clear bus_reset and counter, go to IDLE on that edge; eop_done and eop_err SHALL NOT pulse; SE1 still pulses se1_err.
REQ-026 eop_done and eop_err SHALL never be high in the same cycle.
REQ-027 A new SE0 run SHALL be accepted on the sample immediately after a run terminates, with no dead cycles.

Reset
REQ-028 While n_rst is low, eop, eop_done, eop_err, se1_err and bus_reset SHALL be 0, the counter 0 and the FSM in IDLE, independent of clk.
REQ-029 Reset asserted mid-run (IN_SE0 or RESET_HOLD) SHALL discard the run; no pulse is produced for it after release.
REQ-030 After n_rst rises, the first sampling edge SHALL be processed normally from IDLE.

Verification
REQ-031 Defaults; samples J,SE0,SE0,J -> eop = 1 after the 2nd sample; eop_done pulses once after the 4th sample; eop = 0 after it.
REQ-032 Defaults; samples J,SE0,J -> eop_err pulses once after the 3rd sample; eop_done stays 0.
REQ-033 Defaults; 10 consecutive SE0 samples then J -> bus_reset = 1 from the 8th sample through the 10th, cleared after the J sample; no eop_done or eop_err.
REQ-034 Defaults; SE0,SE0,SE1 -> se1_err and eop_err pulse together once; FSM back in IDLE; next SE0,SE0,J -> eop_done.
REQ-035 EOP_BITS = 3, RESET_BITS = 5; SE0,SE0 with shift_enable low for 20 clks between samples, then SE0,J -> outputs unchanged during the gap; eop_done pulses after the J sample.
REQ-036 Defaults; SE0,SE0, n_rst pulsed low mid-run, then J -> all outputs 0 during reset; no eop_done or eop_err after the J sample.

Source files
------------

// File: rtl/eop_line_monitor.sv
// rtl/eop_line_monitor.sv - end-of-packet, SE1 and bus-reset detector on sampled D+/D- lines
module eop_line_monitor #(
    parameter int EOP_BITS   = 2,
    parameter int RESET_BITS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic shift_enable,
    output logic eop,
    output logic eop_done,
    output logic eop_err,
    output logic se1_err,
    output logic bus_reset
);

    localparam int CW = $clog2(RESET_BITS + 1);
    localparam logic [CW-1:0] RESET_CNT = CW'(RESET_BITS);
    localparam logic [CW-1:0] EOP_CNT   = CW'(EOP_BITS);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        IN_SE0,
        RESET_HOLD
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   se0_cnt;
    logic [CW-1:0]   se0_cnt_nx;
    logic            eop_nx;
    logic            eop_done_nx;
    logic            eop_err_nx;
    logic            se1_err_nx;
    logic            bus_reset_nx;

    logic            is_j;
    logic            is_se0;
    logic            is_se1;

    assign is_j   =  d_plus_sync && !d_minus_sync;
    assign is_se0 = !d_plus_sync && !d_minus_sync;
    assign is_se1 =  d_plus_sync &&  d_minus_sync;

    // State, run counter and all outputs are registered; reset discards any run in progress
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            se0_cnt   <= '0;
            eop       <= 1'b0;
            eop_done  <= 1'b0;
            eop_err   <= 1'b0;
            se1_err   <= 1'b0;
            bus_reset <= 1'b0;
        end else begin
            state     <= state_nx;
            se0_cnt   <= se0_cnt_nx;
            eop       <= eop_nx;
            eop_done  <= eop_done_nx;
            eop_err   <= eop_err_nx;
            se1_err   <= se1_err_nx;
            bus_reset <= bus_reset_nx;
        end
    end

    // Next-state and next-output decode; only sampling edges change anything besides clearing pulses
    always_comb begin
        state_nx     = state;
        se0_cnt_nx   = se0_cnt;
        eop_nx       = eop;
        eop_done_nx  = 1'b0;
        eop_err_nx   = 1'b0;
        se1_err_nx   = 1'b0;
        bus_reset_nx = bus_reset;
        if (shift_enable) begin
            eop_nx     = is_se0;
            se1_err_nx = is_se1;
            case (state)
                IDLE: begin
                    if (is_se0) begin
                        if (RESET_CNT == ONE_CNT) begin
                            state_nx     = RESET_HOLD;
                            se0_cnt_nx   = RESET_CNT;
                            bus_reset_nx = 1'b1;
                        end else begin
                            state_nx   = IN_SE0;
                            se0_cnt_nx = ONE_CNT;
                        end
                    end
                end
                IN_SE0: begin
                    if (is_se0) begin
                        // counter is below RESET_CNT here, so the increment cannot wrap
                        se0_cnt_nx = se0_cnt + ONE_CNT;
                        if (se0_cnt_nx == RESET_CNT) begin
                            state_nx     = RESET_HOLD;
                            bus_reset_nx = 1'b1;
                        end
                    end else begin
                        if (is_j && (se0_cnt >= EOP_CNT)) begin
                            eop_done_nx = 1'b1;
                        end else begin
                            eop_err_nx = 1'b1;
                        end
                        se0_cnt_nx = '0;
                        state_nx   = IDLE;
                    end
                end
                RESET_HOLD: begin
                    if (is_se0) begin
                        se0_cnt_nx = RESET_CNT;
                    end else begin
                        se0_cnt_nx   = '0;
                        bus_reset_nx = 1'b0;
                        state_nx     = IDLE;
                    end
                end
                default: begin
                    state_nx     = IDLE;
                    se0_cnt_nx   = '0;
                    bus_reset_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eop_line_monitor.sv
// tb/tb_eop_line_monitor.sv - randomized and directed bench for eop_line_monitor against a run-length model
module tb_eop_line_monitor;

    localparam logic [1:0] LN_J   = 2'b10;
    localparam logic [1:0] LN_K   = 2'b01;
    localparam logic [1:0] LN_SE0 = 2'b00;
    localparam logic [1:0] LN_SE1 = 2'b11;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic d_plus_sync = 1'b1;
    logic d_minus_sync = 1'b0;
    logic shift_enable = 1'b0;

    logic [1:0] o_eop, o_done, o_err, o_se1, o_br;

    int total = 0;
    int bad = 0;

    int run_len [2];
    int eb_p [2];
    int rb_p [2];
    logic e_eop [2];
    logic e_br [2];
    logic e_done [2];
    logic e_err [2];
    logic e_se1 [2];

    always #5 clk = ~clk;

    eop_line_monitor u_dut_def (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .shift_enable (shift_enable),
        .eop          (o_eop[0]),
        .eop_done     (o_done[0]),
        .eop_err      (o_err[0]),
        .se1_err      (o_se1[0]),
        .bus_reset    (o_br[0])
    );

    eop_line_monitor #(.EOP_BITS(3), .RESET_BITS(5)) u_dut_alt (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .shift_enable (shift_enable),
        .eop          (o_eop[1]),
        .eop_done     (o_done[1]),
        .eop_err      (o_err[1]),
        .se1_err      (o_se1[1]),
        .bus_reset    (o_br[1])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s eop[%0d]", where, k), o_eop[k], e_eop[k]);
            check($sformatf("%s eop_done[%0d]", where, k), o_done[k], e_done[k]);
            check($sformatf("%s eop_err[%0d]", where, k), o_err[k], e_err[k]);
            check($sformatf("%s se1_err[%0d]", where, k), o_se1[k], e_se1[k]);
            check($sformatf("%s bus_reset[%0d]", where, k), o_br[k], e_br[k]);
            check($sformatf("%s excl[%0d]", where, k), o_done[k] & o_err[k], 1'b0);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            run_len[k] = 0;
            e_eop[k] = 1'b0;
            e_br[k] = 1'b0;
            e_done[k] = 1'b0;
            e_err[k] = 1'b0;
            e_se1[k] = 1'b0;
        end
    endtask

    // One clock: drive a line state and strobe, then compare against the run-length reference
    task automatic step(input logic [1:0] ln, input logic se, input string where);
        d_plus_sync = ln[1];
        d_minus_sync = ln[0];
        shift_enable = se;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e_done[k] = 1'b0;
            e_err[k] = 1'b0;
            e_se1[k] = 1'b0;
            if (se) begin
                if (ln == LN_SE0) begin
                    run_len[k] = run_len[k] + 1;
                    e_eop[k] = 1'b1;
                    e_br[k] = (run_len[k] >= rb_p[k]);
                end else begin
                    e_eop[k] = 1'b0;
                    e_se1[k] = (ln == LN_SE1);
                    if (run_len[k] >= rb_p[k]) begin
                        // a run that reached bus reset ends silently
                    end else if (run_len[k] >= eb_p[k] && ln == LN_J) begin
                        e_done[k] = 1'b1;
                    end else if (run_len[k] > 0) begin
                        e_err[k] = 1'b1;
                    end
                    run_len[k] = 0;
                    e_br[k] = 1'b0;
                end
            end
        end
        check_all(where);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock edge
    task automatic pulse_reset(input string where);
        n_rst = 1'b0;
        #1;
        model_clear();
        check_all({where, " async"});
        @(posedge clk);
        #1;
        check_all({where, " held"});
        n_rst = 1'b1;
    endtask

    initial begin
        logic [1:0] ln;
        logic se;
        eb_p[0] = 2; rb_p[0] = 8;
        eb_p[1] = 3; rb_p[1] = 5;
        model_clear();

        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset2");
        n_rst = 1'b1;

        // basic EOP: J,SE0,SE0,J
        step(LN_J, 1'b1, "eop1");
        step(LN_SE0, 1'b1, "eop1");
        step(LN_SE0, 1'b1, "eop1");
        step(LN_J, 1'b1, "eop1");
        step(LN_J, 1'b0, "eop1 idle");

        // short run: J,SE0,J
        step(LN_J, 1'b1, "short");
        step(LN_SE0, 1'b1, "short");
        step(LN_J, 1'b1, "short");

        // bus reset: 10 SE0 then J
        for (int i = 0; i < 10; i++) step(LN_SE0, 1'b1, "busrst");
        step(LN_J, 1'b1, "busrst end");

        // SE1 terminating a run, then immediate new run
        step(LN_SE0, 1'b1, "se1run");
        step(LN_SE0, 1'b1, "se1run");
        step(LN_SE1, 1'b1, "se1run");
        step(LN_SE0, 1'b1, "after se1");
        step(LN_SE0, 1'b1, "after se1");
        step(LN_J, 1'b1, "after se1");

        // K terminating, and back-to-back runs with no gap
        step(LN_SE0, 1'b1, "kterm");
        step(LN_SE0, 1'b1, "kterm");
        step(LN_SE0, 1'b1, "kterm");
        step(LN_K, 1'b1, "kterm");
        step(LN_SE0, 1'b1, "b2b");
        step(LN_SE0, 1'b1, "b2b");
        step(LN_SE0, 1'b1, "b2b");
        step(LN_J, 1'b1, "b2b");

        // gapped samples with the strobe low
        step(LN_SE0, 1'b1, "gap");
        for (int i = 0; i < 20; i++) step(($urandom_range(0, 3) == 0) ? LN_SE1 : LN_J, 1'b0, "gap hold");
        step(LN_SE0, 1'b1, "gap");
        for (int i = 0; i < 20; i++) step(LN_K, 1'b0, "gap hold");
        step(LN_SE0, 1'b1, "gap");
        step(LN_J, 1'b1, "gap end");

        // reset mid-run, then J must not report anything
        step(LN_SE0, 1'b1, "midrst");
        step(LN_SE0, 1'b1, "midrst");
        pulse_reset("midrst");
        step(LN_J, 1'b1, "midrst after");

        // reset during bus reset hold
        for (int i = 0; i < 9; i++) step(LN_SE0, 1'b1, "holdrst");
        pulse_reset("holdrst");
        step(LN_SE0, 1'b1, "holdrst after");
        step(LN_SE0, 1'b1, "holdrst after");
        step(LN_J, 1'b1, "holdrst after");

        // randomized traffic biased toward SE0 runs
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rand");
            end else begin
                ln = ($urandom_range(0, 1) == 0) ? LN_SE0 : 2'($urandom_range(0, 3));
                se = ($urandom_range(0, 3) != 0);
                step(ln, se, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
